// File: rtl/mem_principal.sv
// mem_principal: 32x10 main memory serving L1 fills and write-backs behind a fixed LAT-cycle access.
// Define MEM_WB_FWD_EN to post write-backs to a one-entry buffer that is drained after the fill.
module mem_principal #(
   parameter int unsigned LAT = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       nova_mem,
   input  logic [4:0] endr_mem_in,
   input  logic       wb,
   input  logic [4:0] endr_mem_wb_in,
   input  logic [9:0] dado_mem_wb_in,
   output logic [9:0] dado_mem_out,
   output logic       mem_pronto,
   output logic       ocupado
);
   typedef enum logic [2:0] {
`ifdef MEM_WB_FWD_EN
      DRENA,
`endif
      OCIOSO,
      ESCREVE,
      LE,
      PRONTO
   } estado_t;
   localparam logic [3:0] CARGA = 4'(LAT - 1);
   estado_t    estado_q, estado_d;
   logic [3:0] cnt_q, cnt_d;
   logic [4:0] endr_q, endr_d, endr_wb_q, endr_wb_d;
   logic [9:0] dado_wb_q, dado_wb_d, dado_q, dado_d, fill;
   logic [9:0] mem_q [32];
   logic       pronto_q, pronto_d, we, fim;
`ifdef MEM_WB_FWD_EN
   logic       buf_q, buf_d;
   assign fill = (buf_q && endr_wb_q == endr_q) ? dado_wb_q : mem_q[endr_q] ^ {5'b0, endr_q};
`else
   assign fill = mem_q[endr_q] ^ {5'b0, endr_q};
`endif
   assign fim          = cnt_q == 4'd0;
   assign ocupado      = estado_q != OCIOSO;
   assign mem_pronto   = pronto_q;
   assign dado_mem_out = dado_q;
   // Words are kept XOR their address, so the all-zero power-up state reads back as mem[i] = i.
   always_ff @(posedge clock)
      if (we) mem_q[endr_wb_q] <= dado_wb_q ^ {5'b0, endr_wb_q};
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         estado_q  <= OCIOSO;
         cnt_q     <= '0;
         endr_q    <= '0;
         endr_wb_q <= '0;
         dado_wb_q <= '0;
         dado_q    <= '0;
         pronto_q  <= 1'b0;
`ifdef MEM_WB_FWD_EN
         buf_q     <= 1'b0;
`endif
      end else begin
         estado_q  <= estado_d;
         cnt_q     <= cnt_d;
         endr_q    <= endr_d;
         endr_wb_q <= endr_wb_d;
         dado_wb_q <= dado_wb_d;
         dado_q    <= dado_d;
         pronto_q  <= pronto_d;
`ifdef MEM_WB_FWD_EN
         buf_q     <= buf_d;
`endif
      end
   always_comb begin
      estado_d  = estado_q;
      cnt_d     = cnt_q;
      endr_d    = endr_q;
      endr_wb_d = endr_wb_q;
      dado_wb_d = dado_wb_q;
      dado_d    = dado_q;
      pronto_d  = 1'b0;
      we        = 1'b0;
`ifdef MEM_WB_FWD_EN
      buf_d     = buf_q;
`endif
      case (estado_q)
         OCIOSO:
            if (nova_mem) begin
               endr_d    = endr_mem_in;
               endr_wb_d = endr_mem_wb_in;
               dado_wb_d = dado_mem_wb_in;
               cnt_d     = CARGA;
`ifdef MEM_WB_FWD_EN
               buf_d     = wb;
               estado_d  = LE;
`else
               estado_d  = wb ? ESCREVE : LE;
`endif
            end
         ESCREVE: begin
            we       = fim;
            cnt_d    = fim ? CARGA : cnt_q - 4'd1;
            estado_d = fim ? LE : ESCREVE;
         end
         LE: begin
            cnt_d    = fim ? cnt_q : cnt_q - 4'd1;
            dado_d   = fim ? fill : dado_q;
            pronto_d = fim;
            estado_d = fim ? PRONTO : LE;
         end
`ifdef MEM_WB_FWD_EN
         PRONTO: begin
            cnt_d    = CARGA;
            estado_d = buf_q ? DRENA : OCIOSO;
         end
         DRENA: begin
            we       = fim;
            buf_d    = !fim;
            cnt_d    = fim ? cnt_q : cnt_q - 4'd1;
            estado_d = fim ? OCIOSO : DRENA;
         end
`else
         PRONTO: estado_d = OCIOSO;
`endif
         default: estado_d = OCIOSO;
      endcase
   end
endmodule

// File: tb/tb_mem_principal.sv
// tb_mem_principal: randomized scoreboard bench for mem_principal at LAT=4 (u0) and LAT=1 (u1).
module tb_mem_principal;
`ifdef MEM_WB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   typedef struct {
      logic [9:0] dado;
      int         edge_n;
      bit         ocup;
   } exp_t;
   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       nova [2];
   logic       wbv [2];
   logic [4:0] endr [2];
   logic [4:0] endr_wb [2];
   logic [9:0] dwb [2];
   wire  [9:0] dout [2];
   wire        pronto [2];
   wire        ocup [2];
   int         cyc = 0, checks = 0, errors = 0;
   int         lat [2] = '{4, 1};
   int         free_edge [2] = '{0, 0};
   logic [9:0] ref_mem [2][32];
   exp_t       sb0[$], sb1[$];
   bit         pend [2] = '{0, 0};
   bit         pend_ocup [2] = '{0, 0};

   mem_principal #(.LAT(4)) u0 (
      .clock(clock), .reset_n(reset_n), .nova_mem(nova[0]), .endr_mem_in(endr[0]), .wb(wbv[0]),
      .endr_mem_wb_in(endr_wb[0]), .dado_mem_wb_in(dwb[0]), .dado_mem_out(dout[0]),
      .mem_pronto(pronto[0]), .ocupado(ocup[0]));
   mem_principal #(.LAT(1)) u1 (
      .clock(clock), .reset_n(reset_n), .nova_mem(nova[1]), .endr_mem_in(endr[1]), .wb(wbv[1]),
      .endr_mem_wb_in(endr_wb[1]), .dado_mem_wb_in(dwb[1]), .dado_mem_out(dout[1]),
      .mem_pronto(pronto[1]), .ocupado(ocup[1]));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string nm, input int u, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s u%0d: got %0h, required %0h (edge %0d)", nm, u, act, req, cyc);
      end
   endtask

   // The cycle after each pulse must see the pulse gone and ocupado reflecting a pending drain.
   always @(negedge clock) begin
      exp_t e;
      for (int u = 0; u < 2; u++) begin
         if (pend[u]) begin
            check("pronto_width", u, 32'(pronto[u]), 32'(0));
            check("ocupado_after", u, 32'(ocup[u]), 32'(pend_ocup[u]));
            pend[u] = 1'b0;
         end else if (pronto[u]) begin
            if ((u == 0 ? sb0.size() : sb1.size()) == 0)
               check("pronto_spurious", u, 32'(pronto[u]), 32'(0));
            else begin
               if (u == 0) e = sb0.pop_front();
               else e = sb1.pop_front();
               check("dado", u, 32'(dout[u]), 32'(e.dado));
               check("pronto_edge", u, 32'(cyc), 32'(e.edge_n));
               pend[u]      = 1'b1;
               pend_ocup[u] = e.ocup;
            end
         end
      end
   end

   // Issue one L1 request from a falling edge; the model predicts data, pulse edge and next free edge.
   task automatic req(input int u, input logic [4:0] a, input bit w, input logic [4:0] wa,
                      input logic [9:0] wd, input int gap);
      exp_t e;
      int   acc;
      repeat (gap) @(negedge clock);
      acc    = (cyc + 1 > free_edge[u]) ? cyc + 1 : free_edge[u];
      e.dado = (w && wa == a) ? wd : ref_mem[u][a];
      if (w) ref_mem[u][wa] = wd;
      e.edge_n     = acc + lat[u] + ((w && !FWD) ? lat[u] : 0);
      e.ocup       = w && FWD;
      free_edge[u] = e.edge_n + 2 + (e.ocup ? lat[u] : 0);
      if (u == 0) sb0.push_back(e);
      else sb1.push_back(e);
      nova[u] = 1'b1; endr[u] = a; wbv[u] = w; endr_wb[u] = wa; dwb[u] = wd;
      for (int i = 0; i < 80; i++) begin
         @(negedge clock);
         if (cyc >= acc) begin
            endr[u] = 5'($urandom); wbv[u] = 1'($urandom);
            endr_wb[u] = 5'($urandom); dwb[u] = 10'($urandom);
         end
         if (pronto[u]) break;
      end
      check("pronto_seen", u, 32'(pronto[u]), 32'(1));
      nova[u] = 1'b0;
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         nova[u] = 1'b0; wbv[u] = 1'b0; endr[u] = '0; endr_wb[u] = '0; dwb[u] = '0;
         for (int i = 0; i < 32; i++) ref_mem[u][i] = 10'(i);
      end
      repeat (3) @(negedge clock);
      for (int u = 0; u < 2; u++) begin
         check("rst_pronto", u, 32'(pronto[u]), 32'(0));
         check("rst_dado", u, 32'(dout[u]), 32'(0));
         check("rst_ocupado", u, 32'(ocup[u]), 32'(0));
      end
      reset_n = 1'b1;
      req(0, 5'd5, 0, 5'd0, 10'h0, 0);
      req(0, 5'd9, 1, 5'd1, 10'h3FF, 1);
      req(0, 5'd1, 0, 5'd0, 10'h0, 0);
      req(0, 5'd3, 1, 5'd3, 10'h155, 1);
      req(0, 5'd7, 1, 5'd8, 10'h0AB, 0);
      req(0, 5'd8, 0, 5'd0, 10'h0, 0);
      repeat (10) @(negedge clock);
      nova[0] = 1'b1; endr[0] = 5'd12; wbv[0] = 1'b1; endr_wb[0] = 5'd20; dwb[0] = ~ref_mem[0][20];
      repeat (2) @(negedge clock);
      check("ocupado_busy", 0, 32'(ocup[0]), 32'(1));
      reset_n = 1'b0;
      #1;
      check("arst_pronto", 0, 32'(pronto[0]), 32'(0));
      check("arst_dado", 0, 32'(dout[0]), 32'(0));
      check("arst_ocupado", 0, 32'(ocup[0]), 32'(0));
      nova[0] = 1'b0; wbv[0] = 1'b0;
      repeat (2) @(negedge clock);
      reset_n   = 1'b1;
      free_edge = '{0, 0};
      req(0, 5'd20, 0, 5'd0, 10'h0, 0);
      for (int n = 0; n < 40; n++)
         req(0, 5'($urandom), 1'($urandom), 5'($urandom), 10'($urandom), $urandom_range(0, 3));
      req(1, 5'd0, 0, 5'd0, 10'h0, 0);
      req(1, 5'd31, 0, 5'd0, 10'h0, 0);
      req(1, 5'd4, 1, 5'd4, 10'h2D2, 1);
      for (int n = 0; n < 25; n++)
         req(1, 5'($urandom), 1'($urandom), 5'($urandom), 10'($urandom), $urandom_range(0, 2));
      repeat (12) @(negedge clock);
      check("sb_empty", 0, 32'(sb0.size()), 32'(0));
      check("sb_empty", 1, 32'(sb1.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
